stk_pipe_al_free_list: RTL and testbench

- Allocation free-list manager for the stack pipeline. Hands out and reclaims 10-bit entry pointers.
- Unused entries form a singly linked LIFO list held in the single-port allocation-pointer SRAM (1024 x 10). This block is that SRAM's only master.
- Downstream: it drives the SRAM port. Upstream: it serves alloc and free requests from the stack pipeline.

---
 rtl/stk_pipe_al_free_list_pkg.sv | 19 +
 rtl/stk_pipe_al_free_list_chk.sv | 64 ++++++
 rtl/stk_pipe_al_free_list.sv | 188 ++++++++++++++++++
 tb/tb_stk_pipe_al_free_list.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stk_pipe_al_free_list_pkg.sv
// Shared definitions for the stack-pipeline allocation free list.
//   STK_PIPE_AL_N : number of pointer entries (SRAM depth)
//   STK_PIPE_AL_W : pointer width (SRAM address and data width)
//   al_ptr_t      : one entry pointer
//   al_fl_state_t : free-list controller states
package stk_pipe_pkg;

  localparam int STK_PIPE_AL_N = 1024;
  localparam int STK_PIPE_AL_W = 10;

  typedef logic [STK_PIPE_AL_W-1:0] al_ptr_t;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    IDLE     = 2'd1,
    ALLOC_WB = 2'd2
  } al_fl_state_t;

endpackage

// File: rtl/stk_pipe_al_free_list_chk.sv
// Protocol checker for the allocation free list. Tracks which pointers are
// currently handed out and flags illegal use by the requesters.
// Ports: clk, rst_n, free handshake and pointer, allocation response,
//        free-entry count and init-done status of the free list.
module stk_pipe_al_free_list_chk
  import stk_pipe_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  input logic                   free_vld_i,
  input logic                   free_rdy_i,
  input al_ptr_t                free_ptr_i,
  input logic                   alloc_rsp_vld_i,
  input al_ptr_t                alloc_rsp_ptr_i,
  input logic [STK_PIPE_AL_W:0] count_i,
  input logic                   init_done_i
);

  localparam logic [STK_PIPE_AL_W:0] CNT_FULL = (STK_PIPE_AL_W+1)'(STK_PIPE_AL_N);
  localparam logic [STK_PIPE_AL_W:0] CNT_ONE  = (STK_PIPE_AL_W+1)'(1);

  logic [STK_PIPE_AL_N-1:0] held_q;
  logic [STK_PIPE_AL_W:0]   count_prev_q;
  logic                     free_acc_s;
  logic                     ptr_held_s;

  assign free_acc_s = free_vld_i & free_rdy_i;
  // A pointer handed out this very cycle is already owned by the requester.
  assign ptr_held_s = held_q[free_ptr_i] |
                      (alloc_rsp_vld_i & (alloc_rsp_ptr_i == free_ptr_i));

  // Outstanding-pointer map and previous count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q       <= '0;
      count_prev_q <= '0;
    end else begin
      if (alloc_rsp_vld_i) begin
        held_q[alloc_rsp_ptr_i] <= 1'b1;
      end
      if (free_acc_s) begin
        held_q[free_ptr_i] <= 1'b0;
      end
      count_prev_q <= count_i;
    end
  end

  // Protocol and counter checks.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(free_vld_i && !init_done_i))
        else $error("free list: free requested during init");
      assert (!(free_acc_s && (count_i == CNT_FULL)))
        else $error("free list: free while list is full");
      assert (!(free_acc_s && !ptr_held_s))
        else $error("free list: double free of pointer %0d", free_ptr_i);
      assert (count_i <= CNT_FULL)
        else $error("free list: count %0d above capacity", count_i);
      assert (!((count_prev_q == '0) && (count_i == (count_prev_q - CNT_ONE))))
        else $error("free list: count decremented at zero");
    end
  end

endmodule

// File: rtl/stk_pipe_al_free_list.sv
// Allocation free-list manager. Unused entry pointers form a singly linked
// LIFO list stored in the single-port pointer SRAM. SRAM[p] holds the
// successor of p, and head_q is the top of the list.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_alloc_vld / o_alloc_rdy  allocation request handshake
//   o_alloc_rsp_vld/_ptr       allocated pointer, one-cycle pulse
//   i_free_vld/_ptr, o_free_rdy  pointer return handshake
//   o_sram_*, i_sram_dout      SRAM port (oe=1 read, oe=0 write; dout a cycle later)
//   o_count                    number of free entries
//   o_init_done                list built, block operational
module stk_pipe_al_free_list
  import stk_pipe_pkg::*;
#(
  parameter int N = STK_PIPE_AL_N,
  parameter int W = STK_PIPE_AL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_alloc_vld,
  output logic         o_alloc_rdy,
  output logic         o_alloc_rsp_vld,
  output logic [W-1:0] o_alloc_rsp_ptr,
  input  logic         i_free_vld,
  input  logic [W-1:0] i_free_ptr,
  output logic         o_free_rdy,
  output logic [W-1:0] o_sram_addr,
  output logic [W-1:0] o_sram_din,
  output logic         o_sram_ce,
  output logic         o_sram_oe,
  input  logic [W-1:0] i_sram_dout,
  output logic [W:0]   o_count,
  output logic         o_init_done
);

  localparam logic [W:0]   CNT_FULL = (W+1)'(N);
  localparam logic [W:0]   CNT_ONE  = (W+1)'(1);
  localparam logic [W-1:0] PTR_LAST = W'(N-1);
  localparam logic [W-1:0] PTR_ONE  = W'(1);

  al_fl_state_t state_q, state_d;
  logic [W-1:0] init_cnt_q, init_cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W:0]   count_q, count_d;
  logic         init_done_q, init_done_d;
  logic         alloc_rdy_q, alloc_rdy_d;
  logic         free_rdy_q, free_rdy_d;
  logic         rsp_vld_q, rsp_vld_d;
  logic [W-1:0] rsp_ptr_q, rsp_ptr_d;

  logic         alloc_acc_s;
  logic         free_acc_s;
  logic         sram_ce_s;
  logic         sram_oe_s;
  logic [W-1:0] sram_addr_s;
  logic [W-1:0] sram_din_s;

  // Ready flags are only ever high in IDLE, so acceptance needs no state term.
  assign alloc_acc_s = i_alloc_vld & alloc_rdy_q;
  assign free_acc_s  = i_free_vld & free_rdy_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      head_q      <= '0;
      count_q     <= '0;
      init_done_q <= 1'b0;
      alloc_rdy_q <= 1'b0;
      free_rdy_q  <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_ptr_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      head_q      <= head_d;
      count_q     <= count_d;
      init_done_q <= init_done_d;
      alloc_rdy_q <= alloc_rdy_d;
      free_rdy_q  <= free_rdy_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_ptr_q   <= rsp_ptr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: begin
        if (init_cnt_q == PTR_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = INIT;
        end
      end
      IDLE: begin
        // A bypass (alloc+free together) needs no SRAM read, so it stays in IDLE.
        if (alloc_acc_s && !free_acc_s) begin
          state_d = ALLOC_WB;
        end else begin
          state_d = IDLE;
        end
      end
      ALLOC_WB: state_d = IDLE;
      default:  state_d = INIT;
    endcase
  end

  // Datapath, SRAM port and registered-output next values.
  always_comb begin
    init_cnt_d  = init_cnt_q;
    head_d      = head_q;
    count_d     = count_q;
    init_done_d = init_done_q;
    rsp_vld_d   = 1'b0;
    rsp_ptr_d   = rsp_ptr_q;
    sram_ce_s   = 1'b0;
    sram_oe_s   = 1'b0;
    sram_addr_s = '0;
    sram_din_s  = '0;
    case (state_q)
      INIT: begin
        // Link every entry to its successor; the last entry terminates with 0.
        sram_ce_s   = 1'b1;
        sram_oe_s   = 1'b0;
        sram_addr_s = init_cnt_q;
        if (init_cnt_q == PTR_LAST) begin
          sram_din_s  = '0;
          init_cnt_d  = '0;
          head_d      = '0;
          count_d     = CNT_FULL;
          init_done_d = 1'b1;
        end else begin
          sram_din_s  = init_cnt_q + PTR_ONE;
          init_cnt_d  = init_cnt_q + PTR_ONE;
        end
      end
      IDLE: begin
        if (alloc_acc_s && free_acc_s) begin
          // Hand the returned pointer straight back; list is untouched.
          rsp_vld_d = 1'b1;
          rsp_ptr_d = i_free_ptr;
        end else if (alloc_acc_s) begin
          // Pop: read head's successor, picked up in ALLOC_WB.
          sram_ce_s   = 1'b1;
          sram_oe_s   = 1'b1;
          sram_addr_s = head_q;
          rsp_vld_d   = 1'b1;
          rsp_ptr_d   = head_q;
          count_d     = count_q - CNT_ONE;
        end else if (free_acc_s) begin
          // Push: link the returned pointer in front of the current head.
          sram_ce_s   = 1'b1;
          sram_oe_s   = 1'b0;
          sram_addr_s = i_free_ptr;
          sram_din_s  = head_q;
          head_d      = i_free_ptr;
          count_d     = count_q + CNT_ONE;
        end else begin
          rsp_vld_d = 1'b0;
        end
      end
      ALLOC_WB: begin
        head_d = i_sram_dout;
      end
      default: begin
        rsp_vld_d = 1'b0;
      end
    endcase
    alloc_rdy_d = (state_d == IDLE) && (count_d != '0);
    free_rdy_d  = (state_d == IDLE);
  end

  // SRAM enable is forced off while reset is held so no stray write can occur.
  assign o_sram_ce       = sram_ce_s & rst_n;
  assign o_sram_oe       = sram_oe_s;
  assign o_sram_addr     = sram_addr_s;
  assign o_sram_din      = sram_din_s;
  assign o_alloc_rdy     = alloc_rdy_q;
  assign o_free_rdy      = free_rdy_q;
  assign o_alloc_rsp_vld = rsp_vld_q;
  assign o_alloc_rsp_ptr = rsp_ptr_q;
  assign o_count         = count_q;
  assign o_init_done     = init_done_q;

endmodule

// File: tb/tb_stk_pipe_al_free_list.sv
// Self-checking bench for stk_pipe_al_free_list: directed vector table,
// hand-written corner sequences and randomized traffic against a LIFO model.
module tb_stk_pipe_al_free_list;
  import stk_pipe_pkg::*;

  localparam int N = STK_PIPE_AL_N;
  localparam int W = STK_PIPE_AL_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_alloc_vld, i_free_vld;
  logic [W-1:0] i_free_ptr;
  logic         o_alloc_rdy, o_alloc_rsp_vld, o_free_rdy;
  logic [W-1:0] o_alloc_rsp_ptr;
  logic [W-1:0] o_sram_addr, o_sram_din, sram_dout;
  logic         o_sram_ce, o_sram_oe;
  logic [W:0]   o_count;
  logic         o_init_done;

  logic [W-1:0] mem [N];

  int n_checks = 0;
  int n_errors = 0;
  int stk[$];      // free pointers, front = next to be allocated
  int held[$];     // pointers currently allocated
  bit busy;        // a pop is completing: no request is taken this cycle
  bit last_ce;

  always #5 clk = ~clk;

  stk_pipe_al_free_list dut (
    .clk(clk), .rst_n(rst_n),
    .i_alloc_vld(i_alloc_vld), .o_alloc_rdy(o_alloc_rdy),
    .o_alloc_rsp_vld(o_alloc_rsp_vld), .o_alloc_rsp_ptr(o_alloc_rsp_ptr),
    .i_free_vld(i_free_vld), .i_free_ptr(i_free_ptr), .o_free_rdy(o_free_rdy),
    .o_sram_addr(o_sram_addr), .o_sram_din(o_sram_din), .o_sram_ce(o_sram_ce),
    .o_sram_oe(o_sram_oe), .i_sram_dout(sram_dout),
    .o_count(o_count), .o_init_done(o_init_done)
  );

  stk_pipe_al_free_list_chk u_chk (
    .clk(clk), .rst_n(rst_n),
    .free_vld_i(i_free_vld), .free_rdy_i(o_free_rdy), .free_ptr_i(i_free_ptr),
    .alloc_rsp_vld_i(o_alloc_rsp_vld), .alloc_rsp_ptr_i(o_alloc_rsp_ptr),
    .count_i(o_count), .init_done_i(o_init_done)
  );

  // Single-port SRAM: synchronous write, read data one cycle later.
  always @(posedge clk) begin
    if (o_sram_ce) begin
      if (o_sram_oe) sram_dout <= mem[o_sram_addr];
      else           mem[o_sram_addr] <= o_sram_din;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    stk = {};
    held = {};
    for (int i = 0; i < N; i++) stk.push_back(i);
    busy = 1'b0;
  endtask

  // One clock cycle of requests, checked against the LIFO model.
  // Entered and left 1 time unit after a rising edge.
  task automatic do_cycle(input bit a_vld, input bit f_vld, input int fptr);
    bit ea_rdy, ef_rdy, a_acc, f_acc;
    int top, exp_ptr;
    int idx[$];
    i_alloc_vld = a_vld;
    i_free_vld  = f_vld;
    i_free_ptr  = fptr[W-1:0];
    ea_rdy = !busy && (stk.size() != 0);
    ef_rdy = !busy;
    chk("alloc_rdy", o_alloc_rdy, ea_rdy);
    chk("free_rdy", o_free_rdy, ef_rdy);
    a_acc = a_vld && ea_rdy;
    f_acc = f_vld && ef_rdy;
    top = (stk.size() != 0) ? stk[0] : -1;
    #2;
    last_ce = o_sram_ce;
    if (a_acc && !f_acc) begin
      chk("rd_ce", o_sram_ce, 1);
      chk("rd_oe", o_sram_oe, 1);
      chk("rd_addr", o_sram_addr, top);
    end else if (f_acc && !a_acc) begin
      chk("wr_ce", o_sram_ce, 1);
      chk("wr_oe", o_sram_oe, 0);
      chk("wr_addr", o_sram_addr, fptr);
      if (top >= 0) chk("wr_din", o_sram_din, top);
    end else begin
      chk("no_access_ce", o_sram_ce, 0);
    end
    @(posedge clk); #1;
    exp_ptr = f_acc ? fptr : top;
    if (a_acc && !f_acc) void'(stk.pop_front());
    else if (f_acc && !a_acc) stk.push_front(fptr);
    busy = a_acc && !f_acc;
    if (f_acc) begin
      idx = held.find_first_index(x) with (x == fptr);
      if (idx.size() != 0) held.delete(idx[0]);
    end
    if (a_acc) held.push_back(exp_ptr);
    chk("rsp_vld", o_alloc_rsp_vld, a_acc);
    if (a_acc) chk("rsp_ptr", o_alloc_rsp_ptr, exp_ptr);
    chk("count", o_count, stk.size());
    i_alloc_vld = 1'b0;
    i_free_vld  = 1'b0;
  endtask

  // Watch n init cycles; with full=1 also check the finished list.
  task automatic run_init(input int n, input bit full);
    int bad = 0;
    int mbad = 0;
    for (int k = 0; k < n; k++) begin
      #2;
      if (o_sram_ce !== 1'b1 || o_sram_oe !== 1'b0 || o_sram_addr !== W'(k) ||
          o_sram_din !== W'((k + 1) % N) || o_init_done !== 1'b0 ||
          o_alloc_rdy !== 1'b0 || o_free_rdy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("init_seq", bad, 0);
    if (full) begin
      chk("init_done", o_init_done, 1);
      chk("init_count", o_count, N);
      for (int k = 0; k < N; k++) if (mem[k] !== W'((k + 1) % N)) mbad++;
      chk("init_mem", mbad, 0);
    end
  endtask

  typedef struct {
    bit a;
    bit f;
    int fptr;
    bit exp_ce;
    bit exp_vld;
    int exp_ptr;
    bit exp_rdy;
    int exp_cnt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int fp;
    //                a  f  ptr ce vld ptr rdy count
    vecs[0]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1023};
    vecs[1]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 1023};
    vecs[2]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1, 1'b0, 1022};
    vecs[3]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 1022};
    vecs[4]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 2, 1'b0, 1021};
    vecs[5]  = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 1021};
    vecs[6]  = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 1'b1, 1022};
    vecs[7]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1, 1'b0, 1021};
    vecs[8]  = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 1021};
    vecs[9]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 3, 1'b0, 1020};
    vecs[10] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 1020};
    vecs[11] = '{1'b1, 1'b1, 1, 1'b0, 1'b1, 1, 1'b1, 1020};
    vecs[12] = '{1'b0, 1'b1, 2, 1'b1, 1'b0, 0, 1'b1, 1021};

    rst_n = 1'b0;
    i_alloc_vld = 1'b0;
    i_free_vld = 1'b0;
    i_free_ptr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", o_init_done, 0);
    chk("rst_alloc_rdy", o_alloc_rdy, 0);
    chk("rst_free_rdy", o_free_rdy, 0);
    chk("rst_rsp_vld", o_alloc_rsp_vld, 0);
    chk("rst_sram_ce", o_sram_ce, 0);
    chk("rst_count", o_count, 0);

    model_reset();
    rst_n = 1'b1;
    run_init(N, 1'b1);

    // Directed vectors: pops, a push, LIFO return and a bypass.
    for (int i = 0; i < 13; i++) begin
      do_cycle(vecs[i].a, vecs[i].f, vecs[i].fptr);
      chk("tbl_ce", last_ce, vecs[i].exp_ce);
      chk("tbl_rsp_vld", o_alloc_rsp_vld, vecs[i].exp_vld);
      if (vecs[i].exp_vld) chk("tbl_rsp_ptr", o_alloc_rsp_ptr, vecs[i].exp_ptr);
      chk("tbl_alloc_rdy", o_alloc_rdy, vecs[i].exp_rdy);
      chk("tbl_count", o_count, vecs[i].exp_cnt);
    end

    // Randomized mixed traffic.
    for (int i = 0; i < 800; i++) begin
      bit a, f;
      a = ($urandom_range(0, 1) == 1);
      f = (held.size() != 0) && (stk.size() < N) && ($urandom_range(0, 2) == 0);
      fp = f ? held[$urandom_range(0, held.size() - 1)] : 0;
      do_cycle(a, f, fp);
    end

    // Drain everything, then check the empty behaviour.
    for (int i = 0; i < 3 * N; i++) begin
      if (stk.size() == 0) break;
      do_cycle(1'b1, 1'b0, 0);
    end
    chk("drain_count", o_count, 0);
    do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 0);
    chk("empty_alloc_rdy", o_alloc_rdy, 0);
    do_cycle(1'b1, 1'b1, 7);
    chk("rdy_after_free", o_alloc_rdy, 1);
    do_cycle(1'b1, 1'b0, 0);
    chk("alloc_after_free_vld", o_alloc_rsp_vld, 1);
    chk("alloc_after_free_ptr", o_alloc_rsp_ptr, 7);
    do_cycle(1'b0, 1'b0, 0);

    // Bypass with ten free entries.
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b1, 100 + i);
    chk("pre_bypass_count", o_count, 10);
    do_cycle(1'b1, 1'b1, 5);
    chk("bypass_ce", last_ce, 0);
    chk("bypass_ptr", o_alloc_rsp_ptr, 5);
    chk("bypass_count", o_count, 10);

    // Reset, then reset again in the middle of init.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    run_init(500, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_ce", o_sram_ce, 0);
    @(posedge clk); #1;
    chk("midrst_init_done", o_init_done, 0);
    rst_n = 1'b1;
    run_init(N, 1'b1);
    do_cycle(1'b1, 1'b0, 0);
    chk("first_alloc_after_rst", o_alloc_rsp_ptr, 0);
    do_cycle(1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
